// File: rtl/frame_bank_scheduler.sv
// Ping-pong frame-buffer scheduler: sequences bank fills, picks the VGA read bank, swaps on paced frame boundaries.
// Define PAUSE_EN to add a 'pause' input that freezes swap evaluation during playback.
module frame_bank_scheduler #(
    parameter int NUM_FRAMES    = 6572,
    parameter int STARTUP_TICKS = 2,
    parameter int FRAME_DIV     = 2,
    parameter int IDX_W         = 13
) (
    input  logic             CLK_40,
    input  logic             reset,
    input  logic             vid_start,
    input  logic             frame_tick,
    input  logic             fill_done,
`ifdef PAUSE_EN
    input  logic             pause,
`endif
    output logic             start_req,
    output logic             fill_bank,
    output logic             read_bank1,
    output logic             read_bank2,
    output logic             VGA_startup_en,
    output logic [IDX_W-1:0] frame_idx,
    output logic [7:0]       underrun_cnt,
    output logic             video_done
);

    localparam int TICK_W = $clog2(STARTUP_TICKS + 1);
    localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(STARTUP_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_SAT   = TICK_W'(STARTUP_TICKS);
    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(FRAME_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_FRAMES - 1);
    localparam logic [IDX_W-1:0]  IDX_PENULT = IDX_W'(NUM_FRAMES - 2);

    typedef enum logic [1:0] {S_IDLE, S_STARTUP, S_PLAY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic               fill_pending_q, fill_pending_d;
    logic               start_req_q, start_req_d;
    logic               fill_bank_q, fill_bank_d;
    logic               read_bank1_q, read_bank1_d;
    logic               read_bank2_q, read_bank2_d;
    logic               startup_en_q, startup_en_d;
    logic [IDX_W-1:0]   frame_idx_q, frame_idx_d;
    logic [7:0]         underrun_cnt_q, underrun_cnt_d;
    logic               video_done_q, video_done_d;
    logic               pause_w;
    logic               pending_now;

`ifdef PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    // A fill completing in the same cycle as a decision point counts as done.
    assign pending_now = fill_pending_q & ~fill_done;

    always_comb begin
        state_d        = state_q;
        tick_cnt_d     = tick_cnt_q;
        div_cnt_d      = div_cnt_q;
        fill_pending_d = pending_now;
        start_req_d    = 1'b0;
        fill_bank_d    = fill_bank_q;
        read_bank1_d   = read_bank1_q;
        read_bank2_d   = read_bank2_q;
        startup_en_d   = startup_en_q;
        frame_idx_d    = frame_idx_q;
        underrun_cnt_d = underrun_cnt_q;
        video_done_d   = video_done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (vid_start) begin
                    state_d        = S_STARTUP;
                    start_req_d    = 1'b1;
                    fill_bank_d    = 1'b0;
                    fill_pending_d = 1'b1;
                    tick_cnt_d     = '0;
                    startup_en_d   = 1'b1;
                    read_bank1_d   = 1'b0;
                    read_bank2_d   = 1'b0;
                    frame_idx_d    = '0;
                    video_done_d   = 1'b0;
                end
            end
            S_STARTUP: begin
                if (frame_tick) begin
                    if (tick_cnt_q != TICK_SAT) tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q >= TICK_LAST && !pending_now) begin
                        state_d        = S_PLAY;
                        startup_en_d   = 1'b0;
                        read_bank1_d   = 1'b1;
                        read_bank2_d   = 1'b0;
                        frame_idx_d    = '0;
                        fill_bank_d    = 1'b1;
                        start_req_d    = 1'b1;
                        fill_pending_d = 1'b1;
                        div_cnt_d      = '0;
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick && !pause_w) begin
                    if (div_cnt_q != DIV_LAST) begin
                        div_cnt_d = div_cnt_q + 1'b1;
                    end else if (pending_now) begin
                        // Missed swap: div_cnt stays at the boundary so the next tick retries.
                        if (underrun_cnt_q != 8'hFF) underrun_cnt_d = underrun_cnt_q + 8'd1;
                    end else if (frame_idx_q == IDX_LAST) begin
                        state_d      = S_DONE;
                        read_bank1_d = 1'b0;
                        read_bank2_d = 1'b0;
                        video_done_d = 1'b1;
                    end else begin
                        read_bank1_d = ~read_bank1_q;
                        read_bank2_d = ~read_bank2_q;
                        fill_bank_d  = ~fill_bank_q;
                        frame_idx_d  = frame_idx_q + 1'b1;
                        div_cnt_d    = '0;
                        // Two fills are already issued ahead of the displayed frame.
                        if (frame_idx_q != IDX_PENULT) begin
                            start_req_d    = 1'b1;
                            fill_pending_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state_q        <= S_IDLE;
            tick_cnt_q     <= '0;
            div_cnt_q      <= '0;
            fill_pending_q <= 1'b0;
            start_req_q    <= 1'b0;
            fill_bank_q    <= 1'b0;
            read_bank1_q   <= 1'b0;
            read_bank2_q   <= 1'b0;
            startup_en_q   <= 1'b0;
            frame_idx_q    <= '0;
            underrun_cnt_q <= '0;
            video_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            tick_cnt_q     <= tick_cnt_d;
            div_cnt_q      <= div_cnt_d;
            fill_pending_q <= fill_pending_d;
            start_req_q    <= start_req_d;
            fill_bank_q    <= fill_bank_d;
            read_bank1_q   <= read_bank1_d;
            read_bank2_q   <= read_bank2_d;
            startup_en_q   <= startup_en_d;
            frame_idx_q    <= frame_idx_d;
            underrun_cnt_q <= underrun_cnt_d;
            video_done_q   <= video_done_d;
        end
    end

    assign start_req      = start_req_q;
    assign fill_bank      = fill_bank_q;
    assign read_bank1     = read_bank1_q;
    assign read_bank2     = read_bank2_q;
    assign VGA_startup_en = startup_en_q;
    assign frame_idx      = frame_idx_q;
    assign underrun_cnt   = underrun_cnt_q;
    assign video_done     = video_done_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler: directed playback scenarios plus randomized traffic against a frame-level model.
module tb_frame_bank_scheduler;

    localparam int NF   = 4;
    localparam int ST   = 2;
    localparam int DIV  = 2;
    localparam int IW   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vid_start = 1'b0;
    logic          frame_tick = 1'b0;
    logic          fill_done = 1'b0;
`ifdef PAUSE_EN
    logic          pause = 1'b0;
`endif
    logic          start_req, fill_bank, read_bank1, read_bank2, VGA_startup_en, video_done;
    logic [IW-1:0] frame_idx;
    logic [7:0]    underrun_cnt;

    always #5 clk = ~clk;

    frame_bank_scheduler #(.NUM_FRAMES(NF), .STARTUP_TICKS(ST), .FRAME_DIV(DIV), .IDX_W(IW)) dut (
        .CLK_40(clk),
        .reset(reset),
        .vid_start(vid_start),
        .frame_tick(frame_tick),
        .fill_done(fill_done),
`ifdef PAUSE_EN
        .pause(pause),
`endif
        .start_req(start_req),
        .fill_bank(fill_bank),
        .read_bank1(read_bank1),
        .read_bank2(read_bank2),
        .VGA_startup_en(VGA_startup_en),
        .frame_idx(frame_idx),
        .underrun_cnt(underrun_cnt),
        .video_done(video_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 white startup, 2 playing, 3 done.
    int m_phase = 0, m_ticks = 0, m_sub = 0, m_shown = 0, m_requested = 0, m_ur = 0;
    bit m_pending = 0, m_req = 0, m_new_play = 0, m_entered_done = 0;
    int dut_req_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit vs, input bit ft, input bit fd, input bit rs, input bit ps);
        bit pend_now;
        m_req = 0;
        m_new_play = 0;
        m_entered_done = 0;
        pend_now = m_pending && !fd;
        if (rs) begin
            m_phase = 0; m_ticks = 0; m_sub = 0; m_shown = 0; m_requested = 0; m_ur = 0; m_pending = 0;
            return;
        end
        m_pending = pend_now;
        case (m_phase)
            0, 3: if (vs) begin
                m_phase = 1; m_ticks = 0; m_shown = 0; m_requested = 1;
                m_req = 1; m_pending = 1; m_new_play = 1;
            end
            1: if (ft) begin
                m_ticks++;
                if (m_ticks >= ST && !m_pending) begin
                    m_phase = 2; m_shown = 0; m_sub = 0; m_requested = 2;
                    m_req = 1; m_pending = 1;
                end
            end
            2: if (ft && !ps) begin
                if (m_sub < DIV - 1) m_sub++;
                else if (m_pending) m_ur = (m_ur < 255) ? m_ur + 1 : 255;
                else if (m_shown == NF - 1) begin
                    m_phase = 3; m_entered_done = 1;
                end else begin
                    m_shown++; m_sub = 0;
                    if (m_requested < NF) begin
                        m_requested++; m_req = 1; m_pending = 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        bit playing;
        playing = (m_phase == 2);
        check_val("start_req", start_req, m_req);
        check_val("fill_bank", fill_bank, (m_phase >= 2) ? (m_shown + 1) % 2 : 0);
        check_val("read_bank1", read_bank1, playing && (m_shown % 2 == 0));
        check_val("read_bank2", read_bank2, playing && (m_shown % 2 == 1));
        check_val("startup_en", VGA_startup_en, m_phase == 1);
        check_val("frame_idx", frame_idx, m_shown);
        check_val("underrun_cnt", underrun_cnt, m_ur);
        check_val("video_done", video_done, m_phase == 3);
        if (m_new_play || reset) dut_req_cnt = 0;
        if (start_req === 1'b1) dut_req_cnt++;
        if (m_entered_done) check_val("req_total", dut_req_cnt, NF);
    endtask

    // One clock: drive after the falling edge, model at the rising edge, sample at the next falling edge.
    task automatic cyc(input bit vs, input bit ft, input bit fd, input bit rs, input bit ps);
        bit ps_eff;
        vid_start = vs; frame_tick = ft; fill_done = fd; reset = rs;
`ifdef PAUSE_EN
        pause = ps;
        ps_eff = ps;
`else
        ps_eff = 1'b0;
`endif
        @(posedge clk);
        model_step(vs, ft, fd, rs, ps_eff);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        bit pz;
        @(negedge clk);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check_val("rst_frame_idx", frame_idx, 0);
        // Ticks and fills with no playback request leave everything idle.
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0);
        check_val("idle_req_cnt", dut_req_cnt, 0);

        cyc(1, 0, 0, 0, 0);
        check_val("d_startup_en", VGA_startup_en, 1);
        check_val("d_startup_req", start_req, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check_val("d_still_white", VGA_startup_en, 1);
        cyc(0, 1, 0, 0, 0);
        check_val("d_play_rb1", read_bank1, 1);
        check_val("d_play_fbank", fill_bank, 1);
        check_val("d_play_req", start_req, 1);
        check_val("d_play_white", VGA_startup_en, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check_val("d_underrun", underrun_cnt, 1);
        check_val("d_ur_rb1", read_bank1, 1);
        check_val("d_ur_idx", frame_idx, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check_val("d_swap1_idx", frame_idx, 1);
        check_val("d_swap1_rb2", read_bank2, 1);
        check_val("d_swap1_req", start_req, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check_val("d_simul_idx", frame_idx, 2);
        check_val("d_simul_ur", underrun_cnt, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        check_val("d_last_idx", frame_idx, 3);
        check_val("d_last_noreq", start_req, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        check_val("d_done", video_done, 1);
        check_val("d_done_rb", {read_bank1, read_bank2}, 0);
        cyc(1, 0, 0, 0, 0);
        check_val("d_restart_idx", frame_idx, 0);
        check_val("d_restart_ur", underrun_cnt, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check_val("d_midfill_rst_req", start_req, 0);
        check_val("d_midfill_rst_ur", underrun_cnt, 0);

        pz = 0;
        for (int i = 0; i < 4000; i++) begin
            bit vs, ft, fd, rs;
            vs = ($urandom_range(0, 19) == 0);
            ft = ($urandom_range(0, 5) == 0);
            fd = m_pending ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 49) == 0) pz = ~pz;
            cyc(vs, ft, fd, rs, pz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
